// File: rtl/cnn_pkg.sv
// cnn_pkg: shared pixel/address widths, per-layer feature-map dimensions and buffer state encoding
//   DATA_W/ADDR_W        : pixel and buffer address widths
//   L5_* / L6_*          : feature-map geometry for layer 5 (8x8) and layer 6 (4x4)
//   L5_READY_ROWS        : rows buffered before the layer-6 reader may start
//   buf_state_t          : IDLE/FILL/DONE write-side state
//   relu()               : clamps two's-complement negatives to zero
package cnn_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 7;
    localparam int L5_ROW_LEN = 8;
    localparam int L5_ROWS = 8;
    localparam int L5_DEPTH = L5_ROW_LEN * L5_ROWS;
    localparam int L5_READY_ROWS = 2;
    localparam int L6_ROW_LEN = 4;
    localparam int L6_ROWS = 4;
    localparam int L6_DEPTH = L6_ROW_LEN * L6_ROWS;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } buf_state_t;
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? '0 : v;
    endfunction
endpackage

// File: rtl/conv5_out_buffer_if.sv
// conv5_out_buffer_if: write stream, read port and status flags between the layer-5 side and the buffer
//   master: drives layer_5_buf_begin, wr_valid, wr_data, rd_en, rd_addr;
//           receives rd_data, wr_addr, conv_5_ready, conv_5_write_complete, wr_overflow
//   slave : the buffer, directions reversed
interface conv5_out_buffer_if;
    import cnn_pkg::*;
    logic              layer_5_buf_begin;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              conv_5_ready;
    logic              conv_5_write_complete;
    logic              wr_overflow;
    modport master (
        output layer_5_buf_begin, wr_valid, wr_data, rd_en, rd_addr,
        input  rd_data, wr_addr, conv_5_ready, conv_5_write_complete, wr_overflow
    );
    modport slave (
        input  layer_5_buf_begin, wr_valid, wr_data, rd_en, rd_addr,
        output rd_data, wr_addr, conv_5_ready, conv_5_write_complete, wr_overflow
    );
endinterface

// File: rtl/feature_ram_2r.sv
// feature_ram_2r: simple dual-port feature-map RAM with registered read address and registered read data
//   clk, rst          : clock, synchronous active-high reset (read pipeline only, contents not reset)
//   we, waddr, wdata  : write port
//   re, raddr         : read request; addresses >= DEPTH read as 0
//   rdata             : data two cycles after re/raddr; held when the request had re low
// The array is sampled before the same-edge write lands, so a colliding read returns old data.
module feature_ram_2r #(
    parameter int DW = 8,
    parameter int AW = 7,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic [AW-1:0]            raddr,
    output logic [DW-1:0]            rdata
);
    localparam int IW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic          re_q, re_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    always_comb begin
        re_d = re;
        raddr_d = raddr;
        rdata_d = !re_q ? rdata_q : int'(raddr_q) < DEPTH ? mem[raddr_q[IW-1:0]] : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            re_q <= 1'b0;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            re_q <= re_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/conv5_out_buffer.sv
// conv5_out_buffer: layer-5 output feature-map buffer feeding the layer-6 ReLU/max-pool reader
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : layer_5_buf_begin, wr_valid/wr_data raster write stream, rd_en/rd_addr -> rd_data
//                 (2-cycle read), wr_addr, conv_5_ready, conv_5_write_complete, sticky wr_overflow
// Optional: define CONV5_BUF_RELU_EN to store negative (MSB set) pixels as zero.
module conv5_out_buffer
    import cnn_pkg::*;
#(
    parameter int ROW_LEN = L5_ROW_LEN,
    parameter int ROWS = L5_ROWS,
    parameter int READY_ROWS = L5_READY_ROWS
) (
    input logic             clk,
    input logic             rst,
    conv5_out_buffer_if.slave bus
);
    localparam int DEPTH = ROW_LEN * ROWS;
    localparam int IW = $clog2(DEPTH);
    localparam int COL_W = $clog2(ROW_LEN);
    localparam int ROW_W = $clog2(ROWS + 1);
    buf_state_t        state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ROW_W-1:0]  rows_q, rows_d;
    logic              ready_q, ready_d;
    logic              complete_q, complete_d;
    logic              ovf_q, ovf_d;
    logic              we;
    logic              last;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_data;
    always_comb begin
        state_d = state_q;
        wr_addr_d = wr_addr_q;
        rows_d = rows_q;
        complete_d = complete_q;
        ovf_d = ovf_q;
        // begin wins over a same-cycle write, which is dropped
        we = bus.wr_valid && state_q == FILL && !bus.layer_5_buf_begin;
        last = wr_addr_q == ADDR_W'(DEPTH - 1);
`ifdef CONV5_BUF_RELU_EN
        wdata = relu(bus.wr_data);
`else
        wdata = bus.wr_data;
`endif
        if (bus.layer_5_buf_begin) begin
            state_d = FILL;
            wr_addr_d = '0;
            rows_d = '0;
            complete_d = 1'b0;
            ovf_d = 1'b0;
        end else if (we) begin
            wr_addr_d = last ? '0 : wr_addr_q + 1'b1;
            rows_d = wr_addr_q[COL_W-1:0] == COL_W'(ROW_LEN - 1) ? rows_q + 1'b1 : rows_q;
            state_d = last ? DONE : FILL;
            complete_d = last;
        end else if (bus.wr_valid && state_q != FILL) begin
            ovf_d = 1'b1;
        end
        ready_d = rows_d >= ROW_W'(READY_ROWS);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_addr_q <= '0;
            rows_q <= '0;
            ready_q <= 1'b0;
            complete_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_addr_q <= wr_addr_d;
            rows_q <= rows_d;
            ready_q <= ready_d;
            complete_q <= complete_d;
            ovf_q <= ovf_d;
        end
    end
    feature_ram_2r #(.DW(DATA_W), .AW(ADDR_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_addr_q[IW-1:0]),
        .wdata (wdata),
        .re    (bus.rd_en),
        .raddr (bus.rd_addr),
        .rdata (rd_data)
    );
    assign bus.rd_data = rd_data;
    assign bus.wr_addr = wr_addr_q;
    assign bus.conv_5_ready = ready_q;
    assign bus.conv_5_write_complete = complete_q;
    assign bus.wr_overflow = ovf_q;
endmodule
